// File: rtl/mux_8_way_16_arbiter.sv
// rtl/mux_8_way_16_arbiter.sv - round-robin 8-way 16-bit packet arbiter with registered output stage
// Define MUX_8_WAY_16_ARBITER_LOCK_EN to hold the grant for a whole packet; otherwise arbitration runs per word.
module mux_8_way_16_arbiter (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [7:0]   in_valid,
    input  logic [127:0] in_data,
    input  logic [7:0]   in_last,
    output logic [7:0]   in_ready,
    output logic         out_valid,
    output logic [15:0]  out_data,
    output logic         out_last,
    output logic [2:0]   out_select,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  grant;
    logic [2:0]  grant_nxt;
    logic [2:0]  ptr;
    logic [2:0]  ptr_nxt;

    logic [15:0] rot_wide;
    logic [7:0]  rot;
    logic [2:0]  offset;
    logic [2:0]  pick;
    logic        drain_ok;
    logic        accept;
    logic        end_grant;
    logic [15:0] sel_data;

    // Rotate requests so the search always starts at bit 0, then take the lowest set bit.
    always_comb begin
        rot_wide = {in_valid, in_valid} >> ptr;
        rot      = rot_wide[7:0];
        offset   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                offset = 3'(i);
            end
        end
        pick = ptr + offset;
    end

    assign sel_data = in_data[{grant, 4'b0000} +: 16];
    assign drain_ok = !out_valid || out_ready;
    assign accept   = (state == BUSY) && in_valid[grant] && drain_ok;
    assign in_ready = ((state == BUSY) && drain_ok) ? (8'b0000_0001 << grant) : 8'b0000_0000;
    assign busy     = (state == BUSY);

`ifdef MUX_8_WAY_16_ARBITER_LOCK_EN
    assign end_grant = in_last[grant];
`else
    assign end_grant = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|in_valid) begin
                    grant_nxt = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (accept && end_grant) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= 3'd0;
            ptr   <= 3'd0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // A load in the same cycle as a drain keeps the stage full with the new word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= 16'h0000;
            out_last   <= 1'b0;
            out_select <= 3'd0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= sel_data;
            out_last   <= in_last[grant];
            out_select <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_8_way_16_arbiter.sv
// tb/tb_mux_8_way_16_arbiter.sv - scoreboard bench for mux_8_way_16_arbiter
module tb_mux_8_way_16_arbiter;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [7:0]   in_valid;
    logic [127:0] in_data;
    logic [7:0]   in_last;
    logic [7:0]   in_ready;
    logic         out_valid;
    logic [15:0]  out_data;
    logic         out_last;
    logic [2:0]   out_select;
    logic         out_ready;
    logic         busy;

    mux_8_way_16_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_select (out_select),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [16:0] pmem [8][256];
    int          hd [8];
    int          tl [8];
    logic [19:0] exp_q [$];

    logic        gen_on = 1'b0;
    logic        rand_valid = 1'b0;
    logic        rand_ready = 1'b0;
    logic        ready_val = 1'b1;
    int          seq = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic add_pkt(input int r, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            pmem[r][tl[r] % 256] = {base + 16'(k), (k == n - 1)};
            tl[r] = tl[r] + 1;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #3;
    endtask

    // Producers: drive inputs shortly after each rising edge.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < 8; i++) begin
            if (gen_on && hd[i] == tl[i] && $urandom_range(0, 2) == 0) begin
                seq = seq + 8;
                add_pkt(i, int'($urandom_range(1, 4)), {3'(i), 13'(seq)});
            end
            if (hd[i] != tl[i] && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                in_valid[i]          = 1'b1;
                in_data[i*16 +: 16]  = pmem[i][hd[i] % 256][16:1];
                in_last[i]           = pmem[i][hd[i] % 256][0];
            end else begin
                in_valid[i]          = 1'b0;
                in_data[i*16 +: 16]  = 16'($urandom);
                in_last[i]           = 1'($urandom);
            end
        end
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
    end

    always @(negedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < 8; i++) begin
                if (in_valid[i] && in_ready[i]) hd[i] = hd[i] + 1;
            end
        end
    end

    // Output monitor: every consumed word must be the oldest accepted one.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {12'h0, out_data, out_last, out_select}, 32'hFFFF_FFFF);
            end else begin
                chk("out_word", {12'h0, out_data, out_last, out_select}, {12'h0, exp_q.pop_front()});
            end
        end
    end

    // Reference model: arbitration expressed directly from the rules, one step per cycle.
    logic        m_idle = 1'b1;
    logic [2:0]  m_grant = 3'd0;
    int          m_ptr = 0;
    logic        m_ov = 1'b0;
    logic        p_hold = 1'b0;
    logic [19:0] p_word;

    always @(negedge clock) begin
        #1;
        if (!reset_n) begin
            m_idle  = 1'b1;
            m_grant = 3'd0;
            m_ptr   = 0;
            m_ov    = 1'b0;
            p_hold  = 1'b0;
        end else begin
            logic [7:0] want_ready;
            logic       acc;
            logic       ends;
            int         g;
            g = int'(m_grant);
            want_ready = 8'h00;
            if (!m_idle && (!m_ov || out_ready)) want_ready[g] = 1'b1;
            chk("in_ready", {24'h0, in_ready}, {24'h0, want_ready});
            chk("busy", {31'h0, busy}, {31'h0, !m_idle});
            chk("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
            if (p_hold) chk("stall_stable", {12'h0, out_data, out_last, out_select}, {12'h0, p_word});
            p_hold = m_ov && !out_ready;
            p_word = {out_data, out_last, out_select};
            acc = !m_idle && in_valid[g] && (!m_ov || out_ready);
            if (acc) exp_q.push_back({in_data[g*16 +: 16], in_last[g], m_grant});
            m_ov = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
`ifdef MUX_8_WAY_16_ARBITER_LOCK_EN
            ends = in_last[g];
`else
            ends = 1'b1;
`endif
            if (m_idle) begin
                if (in_valid != 8'h00) begin
                    for (int k = 7; k >= 0; k--) begin
                        if (in_valid[(m_ptr + k) % 8]) m_grant = 3'((m_ptr + k) % 8);
                    end
                    m_idle = 1'b0;
                end
            end else if (acc && ends) begin
                m_idle = 1'b1;
                m_ptr  = (g + 1) % 8;
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        in_valid  = 8'h00;
        in_data   = '0;
        in_last   = 8'h00;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {16'h0, out_data}, 32'h0);
        chk("rst_out_last", {31'h0, out_last}, 32'h0);
        chk("rst_out_select", {29'h0, out_select}, 32'h0);
        chk("rst_in_ready", {24'h0, in_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        wait_cyc(2);
        reset_n = 1'b1;

        add_pkt(0, 3, 16'h0A01);
        wait_cyc(20);

        for (int i = 0; i < 8; i++) add_pkt(i, 1, 16'(i << 4));
        add_pkt(0, 1, 16'h0000);
        wait_cyc(30);

        add_pkt(5, 1, 16'h5555);
        wait_cyc(6);
        add_pkt(0, 1, 16'h0101);
        add_pkt(5, 1, 16'h5556);
        wait_cyc(10);

        add_pkt(3, 4, 16'h3301);
        wait_cyc(3);
        ready_val = 1'b0;
        add_pkt(2, 2, 16'h2201);
        wait_cyc(4);
        ready_val = 1'b1;
        wait_cyc(20);

        add_pkt(4, 4, 16'h4401);
        wait_cyc(3);
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_in_ready", {24'h0, in_ready}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_out_select", {29'h0, out_select}, 32'h0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) hd[i] = tl[i];
        wait_cyc(2);
        add_pkt(4, 2, 16'h4A01);
        reset_n = 1'b1;
        wait_cyc(15);

        add_pkt(1, 2, 16'h1101);
        add_pkt(2, 2, 16'h2201);
        wait_cyc(20);

        gen_on     = 1'b1;
        rand_valid = 1'b1;
        rand_ready = 1'b1;
        wait_cyc(2000);
        gen_on     = 1'b0;
        rand_valid = 1'b0;
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        wait_cyc(150);
        chk("drain_exp_q", exp_q.size(), 32'h0);
        for (int i = 0; i < 8; i++) chk("drain_producer", tl[i] - hd[i], 32'h0);
        chk("drain_out_valid", {31'h0, out_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
